// File: rtl/spring_launch_sequencer_pkg.sv
// Shared state encoding, launch-tuning defaults and compression helpers for the
// launch-lane plunger sequencer.
package spring_launch_sequencer_pkg;

    typedef enum logic [2:0] {IDLE, CHARGE, RELEASE, FIRE, COOLDOWN} launch_state_t;

    localparam int REST_Y_DEFAULT          = 400;
    localparam int MAX_COMPRESS_DEFAULT    = 32;
    localparam int CHARGE_STEP_DEFAULT     = 2;
    localparam int RELEASE_STEP_DEFAULT    = 8;
    localparam int SPEED_GAIN_DEFAULT      = 4;
    localparam int COOLDOWN_FRAMES_DEFAULT = 30;

    localparam int COMP_W = 6;
    localparam int POS_W  = 11;

    // Compression saturates at both ends; it must never wrap.
    function automatic logic [COMP_W-1:0] charge_step(input logic [COMP_W-1:0] c,
                                                      input int step, input int limit);
        int sum;
        sum = int'(c) + step;
        return (sum > limit) ? COMP_W'(limit) : COMP_W'(sum);
    endfunction

    function automatic logic [COMP_W-1:0] release_step(input logic [COMP_W-1:0] c,
                                                       input int step);
        int diff;
        diff = int'(c) - step;
        return (diff <= 0) ? '0 : COMP_W'(diff);
    endfunction

endpackage

// File: rtl/spring_launch_sequencer_frame_countdown.sv
// Frame-tick countdown used for the post-launch re-arm delay.
module frame_countdown #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    // Asserted while the next tick is the last one of the countdown.
    assign done = (count_reg == W'(1));

endmodule

// File: rtl/spring_launch_sequencer.sv
// Launch-lane plunger sequencer: key -> charge / release / fire, driving spring Y
// and a one-shot launch velocity offered over a valid/ack handshake.
module spring_launch_sequencer
    import spring_launch_sequencer_pkg::*;
#(
    parameter int REST_Y          = REST_Y_DEFAULT,
    parameter int MAX_COMPRESS    = MAX_COMPRESS_DEFAULT,
    parameter int CHARGE_STEP     = CHARGE_STEP_DEFAULT,
    parameter int RELEASE_STEP    = RELEASE_STEP_DEFAULT,
    parameter int SPEED_GAIN      = SPEED_GAIN_DEFAULT,
    parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    key5IsPressed,
    input  logic                    reset_level,
    input  logic                    ballInLane,
    input  logic                    launchAck,
    output logic signed [POS_W-1:0] topLeftY,
    output logic                    launchValid,
    output logic signed [POS_W-1:0] launchSpeedY,
    output logic                    busy
);

    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

    logic                    clear;
    launch_state_t           state_reg, state_next;
    logic [COMP_W-1:0]       compression_reg, compression_next;
    logic                    armed_reg, armed_next;
    logic signed [POS_W-1:0] speed_reg, speed_next;
    logic signed [POS_W-1:0] top_reg;
    logic                    valid_reg, busy_reg;
    logic                    cd_load, cd_tick, cd_done;
    logic signed [POS_W-1:0] speed_calc;

    assign clear      = reset | reset_level;
    assign speed_calc = -$signed(POS_W'(compression_reg) * POS_W'(SPEED_GAIN));

    frame_countdown #(.W(CD_W)) u_cooldown (
        .clk        (clk),
        .srst       (clear),
        .load       (cd_load),
        .load_value (CD_W'(COOLDOWN_FRAMES)),
        .tick       (cd_tick),
        .done       (cd_done)
    );

    always_comb begin
        state_next       = state_reg;
        compression_next = compression_reg;
        armed_next       = armed_reg;
        speed_next       = speed_reg;
        cd_load          = 1'b0;
        cd_tick          = 1'b0;

        if (startOfFrame && !key5IsPressed) begin
            armed_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (startOfFrame && key5IsPressed && armed_reg && ballInLane) begin
                    state_next       = CHARGE;
                    compression_next = charge_step('0, CHARGE_STEP, MAX_COMPRESS);
                    armed_next       = 1'b0;
                end
            end
            CHARGE: begin
                if (startOfFrame) begin
                    if (key5IsPressed) begin
                        compression_next = charge_step(compression_reg, CHARGE_STEP, MAX_COMPRESS);
                    end else begin
                        state_next = RELEASE;
                        speed_next = speed_calc;
                    end
                end
            end
            RELEASE: begin
                if (startOfFrame) begin
                    compression_next = release_step(compression_reg, RELEASE_STEP);
                    // Ball presence is only consulted once the spring has fully extended.
                    if (compression_next == '0) begin
                        if (ballInLane) begin
                            state_next = FIRE;
                        end else begin
                            state_next = COOLDOWN;
                            speed_next = '0;
                            cd_load    = 1'b1;
                        end
                    end
                end
            end
            FIRE: begin
                if (valid_reg && launchAck) begin
                    state_next = COOLDOWN;
                    cd_load    = 1'b1;
                end
            end
            COOLDOWN: begin
                if (startOfFrame) begin
                    cd_tick = 1'b1;
                    if (cd_done) begin
                        state_next = IDLE;
                        speed_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg       <= IDLE;
            compression_reg <= '0;
            armed_reg       <= 1'b0;
            speed_reg       <= '0;
            top_reg         <= POS_W'(REST_Y);
            valid_reg       <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            compression_reg <= compression_next;
            armed_reg       <= armed_next;
            speed_reg       <= speed_next;
            top_reg         <= POS_W'(REST_Y + int'(compression_next));
            valid_reg       <= (state_next == FIRE);
            busy_reg        <= (state_next != IDLE);
        end
    end

    assign topLeftY     = top_reg;
    assign launchValid  = valid_reg;
    assign launchSpeedY = speed_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_spring_launch_sequencer.sv
// Directed scoreboard bench for the launch-lane plunger sequencer.
module tb_spring_launch_sequencer;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               key5IsPressed = 1'b0;
    logic               reset_level = 1'b0;
    logic               ballInLane = 1'b1;
    logic               launchAck = 1'b0;
    logic signed [10:0] topLeftY;
    logic               launchValid;
    logic signed [10:0] launchSpeedY;
    logic               busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string tag;
        int    top;
        bit    valid;
        int    speed;
        bit    busy;
    } exp_t;

    exp_t sb[$];

    spring_launch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .key5IsPressed (key5IsPressed),
        .reset_level   (reset_level),
        .ballInLane    (ballInLane),
        .launchAck     (launchAck),
        .topLeftY      (topLeftY),
        .launchValid   (launchValid),
        .launchSpeedY  (launchSpeedY),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic compare_out();
        exp_t e;
        logic [10:0] top_e, spd_e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty got=0 exp=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            top_e = 11'(e.top);
            spd_e = 11'(e.speed);
            checks++;
            assert (topLeftY === top_e) else begin
                failures++;
                $error("FAIL %s topLeftY got=%0d exp=%0d", e.tag, topLeftY, e.top);
            end
            checks++;
            assert (launchValid === e.valid) else begin
                failures++;
                $error("FAIL %s launchValid got=%0b exp=%0b", e.tag, launchValid, e.valid);
            end
            checks++;
            assert (launchSpeedY === spd_e) else begin
                failures++;
                $error("FAIL %s launchSpeedY got=%0d exp=%0d", e.tag, launchSpeedY, e.speed);
            end
            checks++;
            assert (busy === e.busy) else begin
                failures++;
                $error("FAIL %s busy got=%0b exp=%0b", e.tag, busy, e.busy);
            end
            $display("txn %-10s top=%0d valid=%0b speed=%0d busy=%0b", e.tag, topLeftY,
                     launchValid, launchSpeedY, busy);
        end
    endtask

    // One clock cycle: expectation queued as the stimulus is applied, checked after the edge.
    task automatic cyc(input bit sof, input bit ack, input bit rl, input string tag,
                       input int top, input bit valid, input int speed, input bit bsy);
        exp_t e;
        e.tag = tag; e.top = top; e.valid = valid; e.speed = speed; e.busy = bsy;
        sb.push_back(e);
        startOfFrame = sof;
        launchAck    = ack;
        reset_level  = rl;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        launchAck    = 1'b0;
        reset_level  = 1'b0;
        compare_out();
    endtask

    task automatic run_cooldown(input int spd);
        for (int i = 1; i <= 30; i++) begin
            cyc(1, 0, 0, "cooldown", 400, 0, (i < 30) ? spd : 0, (i < 30));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        compare_out_reset();

        // Normal launch
        key5IsPressed = 0;
        cyc(1, 0, 0, "arm", 400, 0, 0, 0);
        key5IsPressed = 1;
        for (int i = 1; i <= 5; i++) cyc(1, 0, 0, "charge", 400 + 2 * i, 0, 0, 1);
        cyc(0, 0, 0, "midframe", 410, 0, 0, 1);
        key5IsPressed = 0;
        cyc(1, 0, 0, "release", 410, 0, -40, 1);
        cyc(1, 0, 0, "rel_step", 402, 0, -40, 1);
        cyc(1, 0, 0, "fire", 400, 1, -40, 1);
        cyc(0, 1, 0, "ack", 400, 0, -40, 1);
        run_cooldown(-40);

        // Saturation, with tick and ack coinciding
        key5IsPressed = 1;
        for (int i = 1; i <= 40; i++)
            cyc(1, 0, 0, "sat", 400 + ((2 * i > 32) ? 32 : 2 * i), 0, 0, 1);
        key5IsPressed = 0;
        cyc(1, 0, 0, "sat_rel", 432, 0, -128, 1);
        cyc(1, 0, 0, "sat_r1", 424, 0, -128, 1);
        cyc(1, 0, 0, "sat_r2", 416, 0, -128, 1);
        cyc(1, 0, 0, "sat_r3", 408, 0, -128, 1);
        cyc(1, 0, 0, "sat_fire", 400, 1, -128, 1);
        cyc(1, 1, 0, "sof_ack", 400, 0, -128, 1);
        run_cooldown(-128);

        // Delayed ack
        key5IsPressed = 1;
        for (int i = 1; i <= 5; i++) cyc(1, 0, 0, "charge", 400 + 2 * i, 0, 0, 1);
        key5IsPressed = 0;
        cyc(1, 0, 0, "release", 410, 0, -40, 1);
        cyc(1, 0, 0, "rel_step", 402, 0, -40, 1);
        cyc(1, 0, 0, "fire", 400, 1, -40, 1);
        for (int i = 0; i < 50; i++) cyc((i % 7) == 0, 0, 0, "hold", 400, 1, -40, 1);
        cyc(0, 1, 0, "late_ack", 400, 0, -40, 1);
        run_cooldown(-40);

        // No ball at release exit
        key5IsPressed = 1;
        for (int i = 1; i <= 3; i++) cyc(1, 0, 0, "nb_chg", 400 + 2 * i, 0, 0, 1);
        ballInLane = 0;
        cyc(1, 0, 0, "nb_chg", 408, 0, 0, 1);
        key5IsPressed = 0;
        cyc(1, 0, 0, "nb_rel", 408, 0, -32, 1);
        cyc(1, 1, 0, "nb_exit", 400, 0, 0, 1);
        run_cooldown(0);
        ballInLane = 1;

        // Restart in CHARGE, held key needs key-up then key-down
        cyc(1, 0, 0, "arm", 400, 0, 0, 0);
        key5IsPressed = 1;
        cyc(1, 0, 0, "charge", 402, 0, 0, 1);
        cyc(0, 0, 1, "rl_charge", 400, 0, 0, 0);
        cyc(1, 0, 0, "held", 400, 0, 0, 0);
        cyc(1, 1, 0, "held_ack", 400, 0, 0, 0);
        cyc(1, 0, 0, "held", 400, 0, 0, 0);
        key5IsPressed = 0;
        cyc(1, 0, 0, "keyup", 400, 0, 0, 0);
        key5IsPressed = 1;
        cyc(1, 0, 0, "keydown", 402, 0, 0, 1);

        // Restart in FIRE
        key5IsPressed = 0;
        cyc(1, 0, 0, "release", 402, 0, -8, 1);
        cyc(1, 0, 0, "fire", 400, 1, -8, 1);
        cyc(0, 0, 0, "fire_hold", 400, 1, -8, 1);
        cyc(0, 0, 1, "rl_fire", 400, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic compare_out_reset();
        exp_t e;
        e.tag = "reset"; e.top = 400; e.valid = 0; e.speed = 0; e.busy = 0;
        sb.push_back(e);
        compare_out();
    endtask

endmodule

// File: doc/spring_launch_sequencer.md
# spring_launch_sequencer

Frame-paced plunger sequencer for the pinball launch lane. It converts the launch key into a charge / release / fire sequence. It drives the spring's vertical position for the spring renderer, and hands a one-shot launch velocity to the ball physics over a valid/ack handshake. It sits between the key decoder and the spring and ball blocks, and replaces free-running spring motion with an explicit state machine.

## Interface
Parameters:
- REST_Y, 400: spring top-left Y at rest, in pixels
- MAX_COMPRESS, 32: maximum compression, in pixels
- CHARGE_STEP, 2: pixels of compression added per frame while charging
- RELEASE_STEP, 8: pixels of compression removed per frame while releasing
- SPEED_GAIN, 4: launch speed per pixel of compression; MAX_COMPRESS*SPEED_GAIN must be ≤ 1023
- COOLDOWN_FRAMES, 30: frames after a launch before the sequencer re-arms

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle frame tick
- key5IsPressed  in  1  launch key level
- reset_level  in  1  synchronous level restart; same effect as reset
- ballInLane  in  1  ball is resting on the spring
- launchAck  in  1  ball physics accepts the launch
- topLeftY  out  11 signed  spring top-left Y
- launchValid  out  1  launch offer pending
- launchSpeedY  out  11 signed  launch vertical speed; negative means upward
- busy  out  1  high whenever state ≠ IDLE

## Operation
- The block has one clock domain and one clock: clk. All outputs are registered.
- reset or reset_level forces the following, with priority over all other inputs:
  - state = IDLE
  - compression = 0, cooldown = 0, armed = 0
  - topLeftY = REST_Y
  - launchValid = 0, launchSpeedY = 0, busy = 0
- armed is a 1-bit flag. It is set on any startOfFrame with key5IsPressed = 0, and cleared on entry to CHARGE. A continuously held key therefore never triggers a second launch.
- The following rules take effect only on a startOfFrame cycle, except the FIRE handshake:
  - **IDLE:** if key pressed, armed and ballInLane → CHARGE, with compression = CHARGE_STEP.
  - **CHARGE:** while the key is pressed, compression = min(compression + CHARGE_STEP, MAX_COMPRESS). When the key is released → RELEASE, and launchSpeedY latches −(compression*SPEED_GAIN).
  - **RELEASE:** compression = max(compression − RELEASE_STEP, 0). On the tick where compression becomes 0:
    - → FIRE if ballInLane
    - → COOLDOWN otherwise, with launchSpeedY = 0
  - **FIRE:** launchValid = 1, and launchSpeedY is held stable. The transfer completes on any cycle with launchValid && launchAck. That cycle → COOLDOWN, with launchValid = 0 on the next cycle and cooldown = COOLDOWN_FRAMES. No timeout applies: the offer holds until ack or reset_level.
  - **COOLDOWN:** cooldown decrements per tick. A tick at cooldown = 1 → IDLE. launchSpeedY is cleared on entry to IDLE.
- Outputs and counters:
  - topLeftY = REST_Y + compression, updated in the same cycle as compression.
  - compression is unsigned 6 bits and saturating at both ends; it never wraps.
  - launchAck outside FIRE is ignored.
  - ballInLane dropping during CHARGE does not abort the charge. It is checked only at the RELEASE exit.

## Timing
- State and compression change on the clk edge that samples startOfFrame = 1. topLeftY is visible from the next cycle for the rest of the frame.
- Key-to-motion latency is at most 1 frame.
- FIRE is entered on a tick edge, and launchValid is high from the cycle after that edge.
- An ack in the first valid cycle gives a 1-cycle handshake.
- A simultaneous startOfFrame and launchAck in FIRE takes the handshake. The cooldown count starts at the following tick.
- reset_level during FIRE drops launchValid on the next cycle, with no transfer.
- Charging MAX_COMPRESS/CHARGE_STEP frames or more saturates compression; further held frames do not change it.

## Structure
- Add the typedef enum logic [2:0] {IDLE, CHARGE, RELEASE, FIRE, COOLDOWN} launch_state_t to the defines package.
- Add the spring rest Y and the launch-tuning constants to defines as the parameter defaults source.
- Sub-module frame_countdown holds the cooldown counter. Its behaviour: load, decrement on tick, and a done flag.
- The FSM and compression datapath stay in the top module.

## Test plan
- **Normal launch:** reset, then one key-up tick to arm. Hold the key for 5 ticks with ballInLane = 1 → compression 2,4,6,8,10 and topLeftY 402..410. On release, launchSpeedY = −40. Two RELEASE ticks (10→2→0) → FIRE with launchValid = 1. Ack in the same cycle → COOLDOWN. IDLE is reached after 30 ticks.
- **Saturation:** hold the key for 40 ticks → compression stops at 32 and topLeftY = 432. Release → launchSpeedY = −128. RELEASE takes 4 ticks.
- **Delayed ack:** withhold launchAck for 50 cycles → launchValid and launchSpeedY = −40 stay stable throughout. Ack → launchValid = 0 on the next cycle.
- **No ball:** drop ballInLane mid-CHARGE → full RELEASE animation, then COOLDOWN with launchValid never asserted and launchSpeedY = 0.
- **Held key:** keep the key pressed through COOLDOWN into IDLE → no new CHARGE until a key-up tick followed by a key-down tick.
- **Mid-sequence restart:** pulse reset_level in CHARGE and again in FIRE → next cycle: IDLE, topLeftY = 400, launchValid = 0, busy = 0.
